// File: rtl/spi_m_tx_if.sv
// Byte-stream handshake plus SPI pin bundle between the host-side byte source and spi_m_tx.
// The master modport is the transmitter's view; slave is the byte source / SPI observer.
interface spi_m_tx_if;
  logic [7:0] i_tx_data;
  logic       i_tx_last;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic       o_spi_clk;
  logic       o_spi_mosi;
  logic       o_spi_nss;
  logic       o_busy;
  logic       o_byte_done;

  modport master (
    input  i_tx_data, i_tx_last, i_tx_valid,
    output o_tx_ready, o_spi_clk, o_spi_mosi, o_spi_nss, o_busy, o_byte_done
  );

  modport slave (
    output i_tx_data, i_tx_last, i_tx_valid,
    input  o_tx_ready, o_spi_clk, o_spi_mosi, o_spi_nss, o_busy, o_byte_done
  );
endinterface

// File: rtl/spi_m_tx.sv
// SPI mode-0 master transmitter with NSS setup/hold/gap framing; all outputs registered.
// Define SPI_M_LSB_FIRST_EN to shift LSB first (default MSB first).
module spi_m_tx #(
  parameter int CLK_DIV   = 4,
  parameter int NSS_SETUP = 4,
  parameter int NSS_HOLD  = 4,
  parameter int NSS_GAP   = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  spi_m_tx_if.master   bus
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int T_MAX0 = (NSS_SETUP > NSS_HOLD) ? NSS_SETUP : NSS_HOLD;
  localparam int T_MAX  = (T_MAX0 > NSS_GAP) ? T_MAX0 : NSS_GAP;
  localparam int T_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(CLK_DIV - 1);
  localparam logic [T_W-1:0]   SETUP_LOAD = T_W'(NSS_SETUP - 1);
  localparam logic [T_W-1:0]   HOLD_LOAD  = T_W'(NSS_HOLD - 1);
  localparam logic [T_W-1:0]   GAP_LOAD   = T_W'(NSS_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Bit-order helpers: the shift register always presents its next bit at one end.
  function automatic logic first_bit(input logic [7:0] b);
`ifdef SPI_M_LSB_FIRST_EN
    return b[0];
`else
    return b[7];
`endif
  endfunction

  function automatic logic [7:0] shift_once(input logic [7:0] b);
`ifdef SPI_M_LSB_FIRST_EN
    return {1'b0, b[7:1]};
`else
    return {b[6:0], 1'b0};
`endif
  endfunction

  state_t           r_state, w_state_next;
  logic [DIV_W-1:0] r_div,   w_div_next;
  logic [2:0]       r_bit,   w_bit_next;
  logic [T_W-1:0]   r_tcnt,  w_tcnt_next;
  logic [7:0]       r_shreg, w_shreg_next;
  logic             r_last,  w_last_next;
  logic             r_sclk,  w_sclk_next;
  logic             r_mosi,  w_mosi_next;
  logic             r_nss,   w_nss_next;
  logic             r_ready, w_ready_next;
  logic             r_busy,  w_busy_next;
  logic             r_done,  w_done_next;

  logic             w_accept;
  logic [7:0]       w_shifted;

  assign w_accept  = bus.i_tx_valid && r_ready;
  assign w_shifted = shift_once(r_shreg);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    w_state_next = r_state;
    w_div_next   = r_div;
    w_bit_next   = r_bit;
    w_tcnt_next  = r_tcnt;
    w_shreg_next = r_shreg;
    w_last_next  = r_last;
    w_sclk_next  = r_sclk;
    w_mosi_next  = r_mosi;
    w_done_next  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_SETUP;
          w_shreg_next = bus.i_tx_data;
          w_last_next  = bus.i_tx_last;
          w_mosi_next  = first_bit(bus.i_tx_data);
          w_tcnt_next  = SETUP_LOAD;
        end
      end

      ST_SETUP: begin
        if (r_tcnt == '0) begin
          w_state_next = ST_SHIFT;
          w_div_next   = DIV_LOAD;
          w_bit_next   = 3'd7;
        end else begin
          w_tcnt_next = r_tcnt - 1'b1;
        end
      end

      ST_SHIFT: begin
        if (r_div != '0) begin
          w_div_next = r_div - 1'b1;
        end else if (!r_sclk) begin
          w_sclk_next = 1'b1;
          w_div_next  = DIV_LOAD;
        end else begin
          // End of the high phase: SCLK falls and MOSI moves on.
          w_sclk_next = 1'b0;
          w_div_next  = DIV_LOAD;
          if (r_bit != 3'd0) begin
            w_bit_next   = r_bit - 1'b1;
            w_shreg_next = w_shifted;
            w_mosi_next  = first_bit(w_shifted);
          end else begin
            w_done_next = 1'b1;
            if (r_last) begin
              w_state_next = ST_HOLD;
              w_tcnt_next  = HOLD_LOAD;
            end else if (w_accept) begin
              w_shreg_next = bus.i_tx_data;
              w_last_next  = bus.i_tx_last;
              w_mosi_next  = first_bit(bus.i_tx_data);
              w_bit_next   = 3'd7;
            end else begin
              w_state_next = ST_WAIT;
            end
          end
        end
      end

      ST_WAIT: begin
        if (w_accept) begin
          w_state_next = ST_SHIFT;
          w_shreg_next = bus.i_tx_data;
          w_last_next  = bus.i_tx_last;
          w_mosi_next  = first_bit(bus.i_tx_data);
          w_div_next   = DIV_LOAD;
          w_bit_next   = 3'd7;
        end
      end

      ST_HOLD: begin
        if (r_tcnt == '0) begin
          w_state_next = ST_GAP;
          w_tcnt_next  = GAP_LOAD;
        end else begin
          w_tcnt_next = r_tcnt - 1'b1;
        end
      end

      ST_GAP: begin
        if (r_tcnt == '0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_tcnt_next = r_tcnt - 1'b1;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    w_nss_next   = (w_state_next == ST_IDLE) || (w_state_next == ST_GAP);
    w_busy_next  = (w_state_next != ST_IDLE);
    w_ready_next = (w_state_next == ST_IDLE) || (w_state_next == ST_WAIT) ||
                   ((w_state_next == ST_SHIFT) && w_sclk_next && (w_div_next == '0) &&
                    (w_bit_next == 3'd0) && !w_last_next);
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_reset) begin
      // NOTE: the small datapath registers are reset too, so MOSI and the framing restart from known values.
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_tcnt  <= '0;
      r_shreg <= '0;
      r_last  <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_nss   <= 1'b1;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_div   <= w_div_next;
      r_bit   <= w_bit_next;
      r_tcnt  <= w_tcnt_next;
      r_shreg <= w_shreg_next;
      r_last  <= w_last_next;
      r_sclk  <= w_sclk_next;
      r_mosi  <= w_mosi_next;
      r_nss   <= w_nss_next;
      r_ready <= w_ready_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  assign bus.o_tx_ready  = r_ready;
  assign bus.o_spi_clk   = r_sclk;
  assign bus.o_spi_mosi  = r_mosi;
  assign bus.o_spi_nss   = r_nss;
  assign bus.o_busy      = r_busy;
  assign bus.o_byte_done = r_done;

endmodule

// File: tb/tb_spi_m_tx.sv
// Self-checking bench for spi_m_tx: drives frames, watches the SPI pins and compares against
// frame-level expectations (bit stream, NSS timing, byte_done spacing, inter-frame gap).
module tb_spi_m_tx;

  localparam int CLK_DIV   = 2;
  localparam int NSS_SETUP = 4;
  localparam int NSS_HOLD  = 4;
  localparam int NSS_GAP   = 4;
  localparam int BYTE_CYC  = 16 * CLK_DIV;

  logic clk;
  logic reset;

  spi_m_tx_if bus ();

  spi_m_tx #(
    .CLK_DIV  (CLK_DIV),
    .NSS_SETUP(NSS_SETUP),
    .NSS_HOLD (NSS_HOLD),
    .NSS_GAP  (NSS_GAP)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- pin monitor (samples on falling clk edge) ----------------
  int   cyc = 0;
  logic bitq[$];
  int   done_q[$];
  logic in_frame = 1'b0;
  logic prev_sclk = 1'b0;
  int   low_cnt = 0, wait_cnt = 0;
  int   frame_cnt = 0, gaps = 0;
  int   gap_cnt = 0, last_gap = -1;
  logic gap_open = 1'b0;
  int   high_run = 0, last_high = -1;
  logic rec_bits[$];
  int   rec_done[$];
  int   rec_len = 0, rec_wait = 0, rec_rise = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      bitq.delete();
      done_q.delete();
      in_frame  = 1'b0;
      gap_open  = 1'b0;
      high_run  = 0;
      prev_sclk = 1'b0;
    end else begin
      if (bus.o_spi_nss === 1'b0) begin
        if (!in_frame) begin
          in_frame  = 1'b1;
          low_cnt   = 0;
          wait_cnt  = 0;
          bitq.delete();
          done_q.delete();
          last_high = high_run;
        end
        low_cnt++;
        if (bus.o_spi_clk && !prev_sclk) bitq.push_back(bus.o_spi_mosi);
        if (bus.o_tx_ready && !bus.o_spi_clk) wait_cnt++;
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          rec_bits = bitq;
          rec_done = done_q;
          rec_len  = low_cnt;
          rec_wait = wait_cnt;
          rec_rise = cyc;
          frame_cnt++;
          gap_cnt  = 0;
          gap_open = 1'b1;
          high_run = 0;
        end
        high_run++;
        if (gap_open) begin
          if (bus.o_tx_ready) begin
            last_gap = gap_cnt;
            gap_open = 1'b0;
            gaps++;
          end else begin
            gap_cnt++;
          end
        end
      end
      if (bus.o_byte_done) done_q.push_back(cyc);
      prev_sclk = bus.o_spi_clk;
    end
  end

  // ---------------- driver ----------------
  task automatic push(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    bus.i_tx_valid = 1'b1;
    bus.i_tx_data  = d;
    bus.i_tx_last  = l;
    while (!bus.o_tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("accept_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic wait_frame(input int f0, input int g0);
    int n = 0;
    while ((frame_cnt <= f0 || gaps <= g0) && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 5000) check("frame_timeout", 0, 1);
  endtask

  // Reference: serial order of each byte and the frame timing rules.
  task automatic check_frame(input logic [7:0] b0, input logic [7:0] b1, input int n, input logic stall);
    logic [15:0] exp_w, got_w;
    logic [7:0]  bb;
    int          base;
    exp_w = '0;
    for (int k = 0; k < n; k++) begin
      bb = (k == 0) ? b0 : b1;
      for (int i = 0; i < 8; i++) begin
`ifdef SPI_M_LSB_FIRST_EN
        exp_w = {exp_w[14:0], bb[i]};
`else
        exp_w = {exp_w[14:0], bb[7-i]};
`endif
      end
    end
    got_w = '0;
    for (int i = 0; i < rec_bits.size() && i < 16; i++) got_w = {got_w[14:0], rec_bits[i]};
    check("rise_edges", rec_bits.size(), 8 * n);
    check("mosi_bits", int'(got_w), int'(exp_w));
    base = NSS_SETUP + n * BYTE_CYC + NSS_HOLD;
    if (stall) begin
      check("wait_len_ge20", int'(rec_wait >= 20), 1);
      check("nss_low_len", rec_len, base + rec_wait);
    end else begin
      check("wait_cycles", rec_wait, 0);
      check("nss_low_len", rec_len, base);
    end
    check("byte_done_cnt", rec_done.size(), n);
    if (rec_done.size() == n) begin
      check("hold_after_done", rec_rise - rec_done[n-1], NSS_HOLD);
      if (n == 2 && !stall) check("done_spacing", rec_done[1] - rec_done[0], BYTE_CYC);
    end
    check("gap_len", last_gap, NSS_GAP);
  endtask

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input int n);
    int f0 = frame_cnt;
    int g0 = gaps;
    push(b0, n == 1);
    if (n == 2) push(b1, 1'b1);
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
    wait_frame(f0, g0);
    check_frame(b0, b1, n, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, g0, n, viol;
    logic [7:0] a, b;

    reset          = 1'b1;
    bus.i_tx_valid = 1'b0;
    bus.i_tx_data  = '0;
    bus.i_tx_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_nss",   bus.o_spi_nss,   1);
    check("rst_sclk",  bus.o_spi_clk,   0);
    check("rst_mosi",  bus.o_spi_mosi,  0);
    check("rst_ready", bus.o_tx_ready,  0);
    check("rst_busy",  bus.o_busy,      0);
    check("rst_done",  bus.o_byte_done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.o_tx_ready, 1);

    // Single byte, then back-to-back pair
    run_frame(8'hA5, 8'h00, 1);
    run_frame(8'h3C, 8'hC3, 2);

    // Stall between bytes: WAIT keeps NSS low, SCLK low, ready high
    f0 = frame_cnt;
    g0 = gaps;
    push(8'h81, 1'b0);
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
    n = 0;
    while (!bus.o_byte_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("stall_done_seen", int'(n < 1000), 1);
    viol = 0;
    repeat (20) begin
      if (bus.o_spi_clk !== 1'b0 || bus.o_tx_ready !== 1'b1 || bus.o_spi_nss !== 1'b0) viol++;
      @(negedge clk);
    end
    check("wait_state_pins", viol, 0);
    push(8'h7E, 1'b1);
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
    wait_frame(f0, g0);
    check_frame(8'h81, 8'h7E, 2, 1'b1);

    // Valid held across HOLD/GAP: next frame starts from the first IDLE cycle
    a  = 8'($urandom);
    b  = 8'($urandom);
    f0 = frame_cnt;
    g0 = gaps;
    push(a, 1'b1);
    push(b, 1'b1);
    check_frame(a, 8'h00, 1, 1'b0);
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
    wait_frame(f0 + 1, g0 + 1);
    check_frame(b, 8'h00, 1, 1'b0);
    check("interframe_high", last_high, NSS_GAP + 1);

    // Reset after three rising SCLK edges
    push(8'($urandom), 1'b1);
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
    n = 0;
    while (bitq.size() < 3 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort_rises_seen", int'(n < 1000), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_nss",   bus.o_spi_nss,  1);
    check("abort_sclk",  bus.o_spi_clk,  0);
    check("abort_mosi",  bus.o_spi_mosi, 0);
    check("abort_busy",  bus.o_busy,     0);
    check("abort_ready", bus.o_tx_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", bus.o_tx_ready, 1);
    run_frame(8'hFF, 8'h00, 1);

    // Bit-order sentinel
    run_frame(8'h01, 8'h00, 1);

    // Randomised frames
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 2));
      run_frame(8'($urandom), 8'($urandom), n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
